// File: rtl/blur_out_pack.sv
// blur_out_pack: rounds/saturates filtered pixels to bytes, packs them four per word, buffers words in a FIFO.
// Ports: iCLK, iRST_N (async active-low) | iDVAL, iDATA upstream pixel stream, never stalled
//        iRDY downstream accept | oDVAL, oDATA, oBE, oEOL, oEOF current FIFO head
//        oOVF sticky word-drop flag | oDONE one-cycle pulse after the EOF word is accepted
module blur_out_pack #(
    parameter int W     = 210,
    parameter int H     = 300,
    parameter int FRAC  = 8,
    parameter int DEPTH = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iDVAL,
    input  logic [15:0] iDATA,
    input  logic        iRDY,
    output logic        oDVAL,
    output logic [31:0] oDATA,
    output logic [3:0]  oBE,
    output logic        oEOL,
    output logic        oEOF,
    output logic        oOVF,
    output logic        oDONE
);
    localparam int CW = (W > 4) ? $clog2(W) : 2;
    localparam int RW = (H > 2) ? $clog2(H) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [16:0]   sum;
    logic [16:0]   rnd;
    logic [7:0]    pix;
    logic          s1_vld;
    logic [7:0]    s1_pix;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [23:0]   acc;
    logic [1:0]    lane;
    logic          last_col;
    logic          last_row;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [31:0]   wdata;
    logic [3:0]    wbe;
    logic [37:0]   mem [DEPTH];
    logic [37:0]   head;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [0:0]    state;

    // 17-bit sum keeps the carry of the rounding add so saturation sees it
    always_comb begin
        sum = {1'b0, iDATA} + (17'd1 << (FRAC - 1));
        rnd = sum >> FRAC;
        pix = (rnd > 17'd255) ? 8'hFF : rnd[7:0];
    end

    assign lane     = col[1:0];
    assign last_col = col == CW'(W - 1);
    assign last_row = row == RW'(H - 1);
    assign push     = s1_vld && (lane == 2'd3 || last_col);
    // lanes 0..2 live in acc; the incoming byte is merged so the word can be pushed this edge
    assign wdata    = {8'd0, acc} | ({24'd0, s1_pix} << {lane, 3'b000});
    assign wbe      = 4'((5'd2 << lane) - 5'd1);

    assign oDVAL = cnt != '0;
    assign full  = cnt == (AW + 1)'(DEPTH);
    assign pop   = oDVAL && iRDY;
    // a full FIFO still accepts when the head leaves on the same edge
    assign wr_en = push && (!full || pop);
    assign head  = mem[rp];
    assign oDATA = oDVAL ? head[31:0] : '0;
    assign oBE   = oDVAL ? head[35:32] : '0;
    assign oEOL  = oDVAL && head[36];
    assign oEOF  = oDVAL && head[37];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_vld <= 1'b0;
            s1_pix <= '0;
            col    <= '0;
            row    <= '0;
            acc    <= '0;
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            oOVF   <= 1'b0;
            oDONE  <= 1'b0;
        end else begin
            s1_vld <= iDVAL;
            s1_pix <= pix;
            if (s1_vld) begin
                acc <= push ? '0 : wdata[23:0];
                col <= last_col ? '0 : col + CW'(1);
                if (last_col)
                    row <= last_row ? '0 : row + RW'(1);
            end
            state <= (state == IDLE) ? (iDVAL ? RUN : IDLE)
                                     : ((push && last_col && last_row) ? IDLE : RUN);
            if (wr_en)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
            cnt <= cnt + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            if (push && !wr_en)
                oOVF <= 1'b1;
            oDONE <= pop && head[37];
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_en)
            mem[wp] <= {last_col && last_row, last_col, wbe, wdata};
    end
endmodule

// File: doc/blur_out_pack.md
BLUR_OUT_PACK -- requirements
Module: blur_out_pack

Interface
REQ-001 Parameter W, default 210, frame width in pixels.
REQ-002 Parameter H, default 300, frame height in rows.
REQ-003 Parameter FRAC, default 8, fractional bits of the incoming unsigned fixed-point pixel.
REQ-004 Parameter DEPTH, default 4, output FIFO depth in words (power of two, >=2).
REQ-005 iCLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 iRST_N  input  1  asynchronous, active-low reset.
REQ-007 iDVAL  input  1  filtered-pixel valid from the upstream blur stage; no backpressure exists upstream.
REQ-008 iDATA  input  16  unsigned fixed-point filtered pixel, FRAC fractional bits.
REQ-009 iRDY  input  1  downstream word-accept.
REQ-010 oDVAL  output  1  output word valid.
REQ-011 oDATA  output  32  packed 8-bit pixels; the lowest column index is in [7:0].
REQ-012 oBE  output  4  byte enables for oDATA.
REQ-013 oEOL  output  1  word is the last of a row.
REQ-014 oEOF  output  1  word is the last of a frame.
REQ-015 oOVF  output  1  sticky overflow flag.
REQ-016 oDONE  output  1  one-cycle pulse when the EOF word is accepted.

Function
REQ-017 Each valid pixel is rounded and saturated in a 17-bit sum: p = (iDATA + 2^(FRAC-1)) >> FRAC, then clamped to 255 if greater than 255.
REQ-018 The rounded byte is registered one cycle after iDVAL is sampled (stage 1).
REQ-019 A column counter (0..W-1) and a row counter (0..H-1) advance once per stage-1 pixel.
REQ-020 A pixel at column c goes to byte lane c mod 4.
REQ-021 A word completes when lane 3 fills or c = W-1, whichever comes first.
REQ-022 A completed word is pushed into the FIFO at the stage-1 edge, so oDVAL rises 2 cycles after the completing pixel is sampled when the FIFO was empty.
REQ-023 oBE holds one bit per filled lane: 4'b1111 for a full word; for the default W, the final row word carries 4'b0011.
REQ-024 oEOL = 1 on the word containing c = W-1.
REQ-025 oEOF = 1 on the word containing c = W-1 and row = H-1.
REQ-026 After the last pixel of a frame, both counters wrap to 0.
REQ-027 The FSM has states IDLE and RUN; IDLE moves to RUN on the first iDVAL, and RUN moves to IDLE when the EOF word is pushed.
REQ-028 Pixel gaps (iDVAL low) freeze the counters and the partial word; no timeout flush occurs.
REQ-029 oDATA, oBE, oEOL and oEOF reflect the FIFO head; oDVAL = FIFO non-empty.
REQ-030 A word pops when oDVAL and iRDY are both high.
REQ-031 On a push with the FIFO full and no pop, the word is dropped, oOVF sets, and the counters still advance.
REQ-032 On a simultaneous push and pop with the FIFO full, both are accepted and nothing is dropped.
REQ-033 On a simultaneous push and pop with the FIFO empty, the word is pushed and no pop occurs; oDVAL rises the next cycle.
REQ-034 oDONE pulses for 1 cycle on the pop of a word with oEOF = 1.
REQ-035 The FIFO, counters and FSM require no interaction with upstream; iDVAL is always consumed.

Reset
REQ-036 While iRST_N = 0, all outputs are 0, the FIFO is empty, the counters are 0, the FSM is IDLE, and oOVF is cleared.
REQ-037 Reset asserted mid-frame discards the partial word and all FIFO contents; the next pixel after release is treated as column 0, row 0.
REQ-038 Only reset clears oOVF.

Verification
REQ-039 Input iDATA = 0x0080, 0x007F, 0xFFFF, 0x1234 at columns 0..3 with iRDY = 1 -> one word with oDATA = 0x12FF0001 and oBE = 4'b1111, oDVAL rising 2 cycles after the 4th pixel.
REQ-040 Input a full 210x300 frame with iRDY = 1 -> 15900 words; every 53rd word has oEOL = 1 and oBE = 4'b0011; the last word has oEOF = 1; oDONE pulses once; oOVF = 0.
REQ-041 Hold iRDY = 0 for 24 continuous pixels -> 4 words are held, the 5th and 6th words are dropped, oOVF = 1, and draining yields exactly 4 words in order.
REQ-042 Hold the FIFO full with iRDY = 1 on the cycle a 4th pixel completes a word -> no drop, oOVF stays 0.
REQ-043 Pulse iRST_N low after 100 pixels, then send a new frame -> outputs are 0 during reset, the first output word carries pixels from column 0, and the frame completes with the correct counts.
REQ-044 Insert random iDVAL gaps across a full frame -> output identical to the gap-free run.
